slip_bus_cycle_ctrl: RTL

- External memory-bus cycle sequencer that drives the 8-bit bidirectional data pad bank.
- Sits directly upstream of the bidirectional pad cells.
  - Generates per-bit pad drive value (A), active-low drive enable (EN) and test-normal (TN).
  - Captures read data from the pads' registered inverted input (ZI).
- Converts single-beat internal read/write requests into timed CS/OE/WE strobe sequences with parameterised wait states.

---
 rtl/slip_bus_pkg.sv | 22 ++
 rtl/slip_bus_cycle_ctrl_if.sv | 42 ++++
 rtl/slip_bus_wait_ctr.sv | 30 +++
 rtl/slip_bus_cycle_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/slip_bus_pkg.sv
// Shared types and constants for the external memory-bus cycle sequencer.
// Optional feature macro: SLIP_BUS_TURNAROUND_EN (adds the TURN state).
package slip_bus_pkg;

  // Width of the wait-state counter; WAIT_STATES must fit in it (0..15).
  localparam int CTR_W = 4;

  // Pad bank data width and default external address width.
  localparam int DATA_W     = 8;
  localparam int ADDR_W_DEF = 20;

  // Bus cycle phases. TURN is only reachable when SLIP_BUS_TURNAROUND_EN is defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    SAMPLE = 3'd3,
    HOLD   = 3'd4,
    TURN   = 3'd5
  } state_t;

endpackage

// File: rtl/slip_bus_cycle_ctrl_if.sv
// Bundle of request-side, memory-strobe and pad-bank signals of the bus
// cycle sequencer. The slave modport is the sequencer's own view; the master
// modport is the view of whatever drives requests and models the pads.
//
// Request handshake: a request is taken on a rising clock edge where req=1
// and busy=0. we/addr/wdata are sampled on that same edge. While busy=1, req
// is ignored (nothing is queued). Completion is a single-cycle ack pulse.
interface slip_bus_cycle_ctrl_if #(
  parameter int ADDR_W = slip_bus_pkg::ADDR_W_DEF
);
  import slip_bus_pkg::*;

  logic                req;
  logic                we;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic                busy;
  logic                ack;
  logic [DATA_W-1:0]   rdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_cs_n;
  logic                mem_oe_n;
  logic                mem_we_n;
  logic [DATA_W-1:0]   pad_a;
  logic                pad_en_n;
  logic                pad_tn;
  logic [DATA_W-1:0]   pad_zi;
  state_t              state;   // debug view of the sequencer FSM

  modport slave (
    input  req, we, addr, wdata, pad_zi,
    output busy, ack, rdata, mem_addr, mem_cs_n, mem_oe_n, mem_we_n,
           pad_a, pad_en_n, pad_tn, state
  );

  modport master (
    output req, we, addr, wdata, pad_zi,
    input  busy, ack, rdata, mem_addr, mem_cs_n, mem_oe_n, mem_we_n,
           pad_a, pad_en_n, pad_tn, state
  );

endinterface

// File: rtl/slip_bus_wait_ctr.sv
// Loadable down-counter that times the STROBE phase; zero marks the last
// strobe cycle.
module slip_bus_wait_ctr
  import slip_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CTR_W-1:0] count;

  // Load takes priority over decrement; the counter never wraps because the
  // controller stops decrementing once zero is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/slip_bus_cycle_ctrl.sv
// External memory-bus cycle sequencer driving an 8-bit bidirectional pad bank.
// Turns single-beat read/write requests into CS/OE/WE strobe sequences with
// WAIT_STATES extra strobe cycles, drives the pad value/enable, and captures
// read data from the pads' registered, inverted input.
// Optional feature macro: SLIP_BUS_TURNAROUND_EN inserts a dead TURN cycle
// after every read so the pads are never driven right after the bus released.
module slip_bus_cycle_ctrl
  import slip_bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_STATES = 2
) (
  input  logic                  MasterClock,
  input  logic                  nReset,
  slip_bus_cycle_ctrl_if.slave  bus
);

  localparam logic [CTR_W-1:0] WS_LOAD = CTR_W'(WAIT_STATES);

  state_t              state;
  state_t              state_nx;

  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]   addr_q;

  logic                accept;
  logic                we_nx;
  logic [DATA_W-1:0]   wdata_nx;
  logic                ctr_zero;
  logic                ctr_dec;

  // Registered outputs and their next values.
  logic                busy_q,   busy_d;
  logic                ack_q,    ack_d;
  logic                cs_n_q,   cs_n_d;
  logic                oe_n_q,   oe_n_d;
  logic                we_n_q,   we_n_d;
  logic                en_n_q,   en_n_d;
  logic [DATA_W-1:0]   pad_a_q,  pad_a_d;
  logic [DATA_W-1:0]   rdata_q;

  assign accept  = (state == IDLE) && bus.req;
  assign ctr_dec = (state == STROBE) && !ctr_zero;

  slip_bus_wait_ctr u_wait_ctr (
    .clk      (MasterClock),
    .rst_n    (nReset),
    .load     (accept),
    .load_val (WS_LOAD),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  // State register.
  always_ff @(posedge MasterClock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Request latch: direction, address and write data held for the whole cycle.
  always_ff @(posedge MasterClock or negedge nReset) begin
    if (!nReset) begin
      we_q    <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else if (accept) begin
      we_q    <= bus.we;
      wdata_q <= bus.wdata;
      addr_q  <= bus.addr;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req) state_nx = SETUP;
      SETUP:   state_nx = STROBE;
      STROBE:  if (ctr_zero) state_nx = we_q ? HOLD : SAMPLE;
      SAMPLE:  state_nx = HOLD;
`ifdef SLIP_BUS_TURNAROUND_EN
      HOLD:    state_nx = we_q ? IDLE : TURN;
      TURN:    state_nx = IDLE;
`else
      HOLD:    state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Output decode from the state being entered, so every output is a flop
  // whose value during a cycle reflects that cycle's state. On the accepting
  // edge the latch has not updated yet, so the live request fields are used.
  always_comb begin
    we_nx    = accept ? bus.we    : we_q;
    wdata_nx = accept ? bus.wdata : wdata_q;

    busy_d  = (state_nx != IDLE);
    ack_d   = (state_nx == HOLD);
    cs_n_d  = !(state_nx inside {SETUP, STROBE, SAMPLE, HOLD});
    oe_n_d  = !(!we_nx && (state_nx inside {SETUP, STROBE, SAMPLE}));
    we_n_d  = !(we_nx && (state_nx == STROBE));
    en_n_d  = !(we_nx && (state_nx inside {SETUP, STROBE, HOLD}));
    pad_a_d = pad_a_q;
    if (!en_n_d) begin
      pad_a_d = wdata_nx;
    end
  end

  // Output registers; reset leaves every strobe and the pad drive inactive.
  always_ff @(posedge MasterClock or negedge nReset) begin
    if (!nReset) begin
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      en_n_q  <= 1'b1;
      pad_a_q <= '0;
    end else begin
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      en_n_q  <= en_n_d;
      pad_a_q <= pad_a_d;
    end
  end

  // Read capture at the end of SAMPLE; the pad input flop inverts and delays
  // the pin by one cycle, which the extra SAMPLE cycle absorbs.
  always_ff @(posedge MasterClock or negedge nReset) begin
    if (!nReset) begin
      rdata_q <= '0;
    end else if (state == SAMPLE) begin
      rdata_q <= ~bus.pad_zi;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_cs_n = cs_n_q;
  assign bus.mem_oe_n = oe_n_q;
  assign bus.mem_we_n = we_n_q;
  assign bus.pad_a    = pad_a_q;
  assign bus.pad_en_n = en_n_q;
  assign bus.pad_tn   = 1'b1;
  assign bus.state    = state;

  // Output enable and write enable are mutually exclusive on the bus.
  a_oe_we_excl : assert property (@(posedge MasterClock) disable iff (!nReset)
    !(!oe_n_q && !we_n_q));

  // The pads never drive while the memory is driving the bus.
  a_en_oe_excl : assert property (@(posedge MasterClock) disable iff (!nReset)
    !(!en_n_q && !oe_n_q));

endmodule
